// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the 5-stage MIPS pipeline.
// Merges the ID/EX/MEM stall requests into the shared stall bus and sequences
// redirect flushes. It also provides a stall watchdog and stall statistics.
// Stall bus bits: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
// A 1 on a bit means that stage holds. The first stage above the highest
// held stage loads a bubble.
module pipe_stall_ctrl #(
    parameter int STALL_WD = 6,
    parameter int TIMEOUT  = 1024,
    parameter int CNT_WD   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_id,
    input  logic                stallreq_ex,
    input  logic                stallreq_mem,
    input  logic                flush_req,
    input  logic [31:0]         flush_req_pc,
    output logic [STALL_WD-1:0] stall,
    output logic                flush,
    output logic [31:0]         new_pc,
    output logic                stall_timeout,
    output logic [CNT_WD-1:0]   stall_cycles,
    output logic [CNT_WD-1:0]   loaduse_events
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    // Stall patterns. Each pattern holds everything up to and including the
    // requesting stage.
    localparam logic [STALL_WD-1:0] STALL_NONE = '0;
    localparam logic [STALL_WD-1:0] STALL_ID   = STALL_WD'(7);
    localparam logic [STALL_WD-1:0] STALL_EX   = STALL_WD'(15);
    localparam logic [STALL_WD-1:0] STALL_MEM  = STALL_WD'(31);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t          state;
    logic [WD_W-1:0] wd_cnt;
    logic            prev_loaduse;
    logic            stall_any;
    logic            loaduse_now;

    // The flush output is the FSM state itself. It is registered and so
    // arrives one cycle after flush_req.
    assign flush = (state == FLUSH);

    // Combinational stall merge with priority MEM > EX > ID. During a
    // flush cycle all requests are ignored, because the pipeline is being
    // emptied.
    always_comb begin
        stall = STALL_NONE;
        if (state == RUN) begin
            if (stallreq_mem)
                stall = STALL_MEM;
            else if (stallreq_ex)
                stall = STALL_EX;
            else if (stallreq_id)
                stall = STALL_ID;
        end
    end

    assign stall_any   = (stall != STALL_NONE);
    assign loaduse_now = (stall == STALL_ID);

    // Redirect FSM. Every flush_req loads a new PC. This includes
    // back-to-back requests, which keep flush high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= RUN;
            new_pc <= 32'h0;
        end else begin
            case (state)
                RUN: begin
                    if (flush_req) begin
                        state  <= FLUSH;
                        new_pc <= flush_req_pc;
                    end
                end
                FLUSH: begin
                    if (flush_req) begin
                        state  <= FLUSH;
                        new_pc <= flush_req_pc;
                    end else begin
                        state  <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Watchdog: count consecutive stalled cycles, saturating at TIMEOUT.
    // The flag goes high on the edge where the count reaches TIMEOUT and
    // stays high until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt        <= '0;
            stall_timeout <= 1'b0;
        end else begin
            if (!stall_any)
                wd_cnt <= '0;
            else if (wd_cnt != WD_W'(TIMEOUT))
                wd_cnt <= wd_cnt + WD_W'(1);
            if (stall_any && (wd_cnt >= WD_W'(TIMEOUT - 1)))
                stall_timeout <= 1'b1;
        end
    end

    // Statistics: stalled-cycle count, and load-use episodes counted on the
    // rising edge of the effective ID-only stall. Both counters wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles   <= '0;
            loaduse_events <= '0;
            prev_loaduse   <= 1'b0;
        end else begin
            prev_loaduse <= loaduse_now;
            if (stall_any)
                stall_cycles <= stall_cycles + CNT_WD'(1);
            if (loaduse_now && !prev_loaduse)
                loaduse_events <= loaduse_events + CNT_WD'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl. A driver applies directed and
// random request patterns. For each cycle it pushes the expected outputs,
// taken from a behavioural model, into a queue. A monitor pops each entry
// and compares it with the DUT outputs.
module tb_pipe_stall_ctrl;

    localparam int TO    = 4;
    localparam int EXP_W = 6 + 1 + 32 + 1 + 32 + 32;

    logic        clk;
    logic        rst;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        flush_req;
    logic [31:0] flush_req_pc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
    logic [31:0] stall_cycles;
    logic [31:0] loaduse_events;

    pipe_stall_ctrl #(
        .STALL_WD (6),
        .TIMEOUT  (TO),
        .CNT_WD   (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_id    (stallreq_id),
        .stallreq_ex    (stallreq_ex),
        .stallreq_mem   (stallreq_mem),
        .flush_req      (flush_req),
        .flush_req_pc   (flush_req_pc),
        .stall          (stall),
        .flush          (flush),
        .new_pc         (new_pc),
        .stall_timeout  (stall_timeout),
        .stall_cycles   (stall_cycles),
        .loaduse_events (loaduse_events)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int               errors = 0;
    int               checks = 0;
    logic [EXP_W-1:0] exp_q[$];
    event             chk_now;

    // Behavioural model. It holds the values that the registered outputs
    // show after the most recent edge.
    logic        m_flush;
    logic [31:0] m_pc;
    logic        m_to;
    logic [31:0] m_sc;
    logic [31:0] m_lu;
    int          m_run;
    logic        m_prev_lu;

    task automatic model_reset();
        m_flush   = 1'b0;
        m_pc      = 32'h0;
        m_to      = 1'b0;
        m_sc      = 32'h0;
        m_lu      = 32'h0;
        m_run     = 0;
        m_prev_lu = 1'b0;
    endtask

    // Expected stall bus: hold every stage up to the requester. MEM has
    // priority over EX, and EX over ID. Nothing is held in a flush cycle.
    function automatic logic [5:0] ref_stall(input logic fl, input logic mem,
                                             input logic ex, input logic id);
        int top;
        logic [5:0] s;
        top = mem ? 4 : ex ? 3 : id ? 2 : -1;
        s = 6'h0;
        if (!fl)
            for (int k = 0; k <= top; k++) s[k] = 1'b1;
        return s;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic id, input logic ex, input logic mem,
                         input logic fr, input logic [31:0] pc);
        logic [5:0] s;
        @(posedge clk);
        #1;
        stallreq_id  = id;
        stallreq_ex  = ex;
        stallreq_mem = mem;
        flush_req    = fr;
        flush_req_pc = pc;
        s = ref_stall(m_flush, mem, ex, id);
        exp_q.push_back({s, m_flush, m_pc, m_to, m_sc, m_lu});
        // Advance the model to the values after the next edge.
        if (s != 6'h0) begin
            m_sc  = m_sc + 1;
            m_run = m_run + 1;
        end else begin
            m_run = 0;
        end
        if (m_run >= TO) m_to = 1'b1;
        if (s == 6'b000111 && !m_prev_lu) m_lu = m_lu + 1;
        m_prev_lu = (s == 6'b000111);
        if (fr) m_pc = pc;
        m_flush = fr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic clear_inputs();
        stallreq_id  = 1'b0;
        stallreq_ex  = 1'b0;
        stallreq_mem = 1'b0;
        flush_req    = 1'b0;
        flush_req_pc = 32'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        exp_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- monitor ----------------
    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [EXP_W-1:0] e;
        forever begin
            @(negedge clk or chk_now);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stall",          {26'h0, stall},     {26'h0, e[103:98]});
                chk("flush",          {31'h0, flush},     {31'h0, e[97]});
                chk("new_pc",         new_pc,             e[96:65]);
                chk("stall_timeout",  {31'h0, stall_timeout}, {31'h0, e[64]});
                chk("stall_cycles",   stall_cycles,       e[63:32]);
                chk("loaduse_events", loaduse_events,     e[31:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        clear_inputs();
        rst = 1'b0;
        model_reset();
        #1;
        // Reset values must be present before any clock edge.
        exp_q.push_back('0);
        ->chk_now;
        #1;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Idle after reset.
        idle(10);
        // Single-cycle load-use.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(2);
        // EX busy for 3 cycles, with load-use masked in cycle 2.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        idle(2);
        // Flush request while MEM is waiting. The request is ignored during
        // the flush cycle.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'hBFC00380);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        idle(2);
        // Back-to-back flushes.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h00000100);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h00000200);
        idle(3);
        // Watchdog: MEM stall held for 6 cycles.
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        idle(3);

        // Async reset in the middle of a flush.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEE0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        exp_q.push_back('0);
        ->chk_now;
        #1;
        @(negedge clk);
        rst = 1'b1;
        idle(3);

        // Random traffic with occasional resets.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 300; i++) begin
                drive($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                      $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                      $urandom);
            end
            // Hold MEM long enough for the watchdog to trip in each segment.
            for (int i = 0; i < TO + 2; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
            idle(2);
            do_reset();
        end

        idle(2);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
